// File: rtl/l2_lru_pkg.sv
// Shared widths and types for the L2 pseudo-LRU replacement controller.
package l2_lru_pkg;

    localparam int DEFAULT_NUM_SETS = 256;
    localparam int DEFAULT_NUM_WAYS = 8;

    function automatic int tree_bits(input int num_ways);
        return num_ways - 1;
    endfunction

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [index_width(DEFAULT_NUM_SETS)-1:0] set_idx_t;
    typedef logic [index_width(DEFAULT_NUM_WAYS)-1:0] way_idx_t;
    typedef logic [DEFAULT_NUM_WAYS-1:0]              lock_mask_t;

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational PLRU helpers: lock-aware victim walk for the fill set and
// chained MRU updates (access first, then fill) for merged same-set writes.
module plru_tree_logic
    import l2_lru_pkg::*;
#(
    parameter  int NUM_WAYS = 8,
    localparam int TREE_W   = tree_bits(NUM_WAYS),
    localparam int WAY_W    = index_width(NUM_WAYS)
) (
    input  logic [TREE_W-1:0]   fill_tree,
    input  logic [NUM_WAYS-1:0] fill_lock,
    input  logic [TREE_W-1:0]   acc_tree,
    input  logic [WAY_W-1:0]    acc_way,
    input  logic                merge_acc,
    output logic [WAY_W-1:0]    victim_way,
    output logic                victim_valid,
    output logic [TREE_W-1:0]   acc_tree_next,
    output logic [TREE_W-1:0]   fill_tree_next
);

    function automatic logic [TREE_W-1:0] mru_update(input logic [TREE_W-1:0] tree,
                                                     input logic [WAY_W-1:0]  way);
        logic [TREE_W-1:0] upd;
        logic [WAY_W-1:0]  path;
        int                node;
        upd  = tree;
        path = way;
        node = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            for (int n = 0; n < TREE_W; n++) begin
                if (n == node) upd[n] = ~path[WAY_W-1];
            end
            node = 2 * node + (path[WAY_W-1] ? 2 : 1);
            path = path << 1;
        end
        return upd;
    endfunction

    int   walk_node;
    int   walk_lo;
    int   walk_half;
    logic lo_full;
    logic hi_full;
    logic node_bit;
    logic go_hi;

    // A subtree whose ways are all locked is skipped even if its node bit points at it.
    always_comb begin
        walk_node = 0;
        walk_lo   = 0;
        walk_half = NUM_WAYS / 2;
        lo_full   = 1'b0;
        hi_full   = 1'b0;
        node_bit  = 1'b0;
        go_hi     = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            lo_full  = 1'b1;
            hi_full  = 1'b1;
            node_bit = 1'b0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (w >= walk_lo && w < walk_lo + walk_half)
                    lo_full = lo_full & fill_lock[w];
                if (w >= walk_lo + walk_half && w < walk_lo + 2 * walk_half)
                    hi_full = hi_full & fill_lock[w];
            end
            for (int n = 0; n < TREE_W; n++) begin
                if (n == walk_node) node_bit = fill_tree[n];
            end
            go_hi = node_bit ? !hi_full : lo_full;
            if (go_hi) walk_lo = walk_lo + walk_half;
            walk_node = 2 * walk_node + (go_hi ? 2 : 1);
            walk_half = walk_half / 2;
        end
    end

    assign victim_valid   = ~&fill_lock;
    assign victim_way     = victim_valid ? WAY_W'(walk_lo) : '0;
    assign acc_tree_next  = mru_update(acc_tree, acc_way);
    assign fill_tree_next = mru_update(merge_acc ? acc_tree_next : fill_tree, victim_way);

endmodule

// File: rtl/l2_cache_lock_lru.sv
// L2 pseudo-LRU replacement controller with per-way locks; owns the per-set
// tree and lock flops, the stage-1 request registers and update merging.
module l2_cache_lock_lru
    import l2_lru_pkg::*;
#(
    parameter  int NUM_SETS        = 256,
    parameter  int NUM_WAYS        = 8,
    localparam int SET_INDEX_WIDTH = index_width(NUM_SETS),
    localparam int WAY_INDEX_WIDTH = index_width(NUM_WAYS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fill_en,
    input  logic [SET_INDEX_WIDTH-1:0] fill_set,
    output logic [WAY_INDEX_WIDTH-1:0] fill_way,
    output logic                       fill_way_valid,
    input  logic                       access_en,
    input  logic [SET_INDEX_WIDTH-1:0] access_set,
    input  logic                       access_update_en,
    input  logic [WAY_INDEX_WIDTH-1:0] access_update_way,
    input  logic                       lock_en,
    input  logic [SET_INDEX_WIDTH-1:0] lock_set,
    input  logic [WAY_INDEX_WIDTH-1:0] lock_way,
    input  logic                       lock_value
);

    localparam int TREE_W = tree_bits(NUM_WAYS);

    logic [TREE_W-1:0]          tree_q [NUM_SETS];
    logic [TREE_W-1:0]          tree_d [NUM_SETS];
    logic [NUM_WAYS-1:0]        lock_q [NUM_SETS];
    logic [NUM_WAYS-1:0]        lock_d [NUM_SETS];
    logic                       fill_vld_q, fill_vld_d;
    logic [SET_INDEX_WIDTH-1:0] fill_set_q, fill_set_d;
    logic                       acc_vld_q, acc_vld_d;
    logic [SET_INDEX_WIDTH-1:0] acc_set_q, acc_set_d;

    logic [WAY_INDEX_WIDTH-1:0] victim_way;
    logic                       victim_valid;
    logic [TREE_W-1:0]          acc_tree_next;
    logic [TREE_W-1:0]          fill_tree_next;
    logic                       acc_upd;
    logic                       fill_upd;

    assign acc_upd  = acc_vld_q & access_update_en;
    assign fill_upd = fill_vld_q & victim_valid;

    plru_tree_logic #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .fill_tree      (tree_q[fill_set_q]),
        .fill_lock      (lock_q[fill_set_q]),
        .acc_tree       (tree_q[acc_set_q]),
        .acc_way        (access_update_way),
        .merge_acc      (acc_upd && (acc_set_q == fill_set_q)),
        .victim_way     (victim_way),
        .victim_valid   (victim_valid),
        .acc_tree_next  (acc_tree_next),
        .fill_tree_next (fill_tree_next)
    );

    assign fill_way_valid = fill_upd;
    assign fill_way       = fill_upd ? victim_way : '0;

    // The fill write comes last so a same-set fill overrides the access result.
    always_comb begin
        tree_d     = tree_q;
        lock_d     = lock_q;
        fill_vld_d = fill_en;
        fill_set_d = fill_set;
        acc_vld_d  = access_en;
        acc_set_d  = access_set;
        if (acc_upd)  tree_d[acc_set_q]  = acc_tree_next;
        if (fill_upd) tree_d[fill_set_q] = fill_tree_next;
        if (lock_en)  lock_d[lock_set][lock_way] = lock_value;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tree_q     <= '{default: '0};
            lock_q     <= '{default: '0};
            fill_vld_q <= 1'b0;
            fill_set_q <= '0;
            acc_vld_q  <= 1'b0;
            acc_set_q  <= '0;
        end else begin
            tree_q     <= tree_d;
            lock_q     <= lock_d;
            fill_vld_q <= fill_vld_d;
            fill_set_q <= fill_set_d;
            acc_vld_q  <= acc_vld_d;
            acc_set_q  <= acc_set_d;
        end
    end

endmodule

// File: doc/l2_cache_lock_lru.md
# l2_cache_lock_lru

Parametrised pseudo-LRU replacement controller for the L2 cache with per-way lock bits. It keeps a binary-tree PLRU state and a lock mask for every set. Fill victims never land on a locked way, and the block reports when a set has no replaceable way. It sits beside the L2 tag array and follows the same two-stage fill/access timing as the tag pipeline.

## Interface
- NUM_SETS, 256, number of sets; power of two, ≥1
- NUM_WAYS, 8, ways per set; power of two, 2..16
- SET_INDEX_WIDTH, $clog2(NUM_SETS) (min 1), derived
- WAY_INDEX_WIDTH, $clog2(NUM_WAYS), derived

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- fill_en  in  1  stage 1: request victim for fill_set
- fill_set  in  SET_INDEX_WIDTH  set to fill
- fill_way  out  WAY_INDEX_WIDTH  stage 2: chosen victim way
- fill_way_valid  out  1  stage 2: 1 = victim found; 0 = no fill this cycle, or all ways locked
- access_en  in  1  stage 1: tag lookup on access_set
- access_set  in  SET_INDEX_WIDTH  looked-up set
- access_update_en  in  1  stage 2: hit; mark access_update_way as MRU
- access_update_way  in  WAY_INDEX_WIDTH  hit way
- lock_en  in  1  write lock bit
- lock_set  in  SET_INDEX_WIDTH  set to lock/unlock
- lock_way  in  WAY_INDEX_WIDTH  way to lock/unlock
- lock_value  in  1  1 = lock, 0 = unlock

## Operation
- Per set: NUM_WAYS-1 tree bits, node 0 = root, children of node n at 2n+1 and 2n+2. Bit 0 means the victim lies in the lower-index half. Per set: a NUM_WAYS lock mask.
- Victim walk: start at the root. Follow the node bit unless every way in that child subtree is locked; in that case take the other child. If all ways of the set are locked: fill_way_valid=0, fill_way=0, no tree update.
- MRU update for way w: set every node on w's path to point away from w.
- A fill with a valid victim performs an MRU update on the victim. access_update_en performs an MRU update on access_update_way in the set latched from access_en.
- If a fill update and an access update hit the same set in the same cycle, the access update is applied first and the fill update second. Where both write the same node bit, the fill value wins.
- A lock write takes effect at the end of its cycle. Lock bits do not alter tree bits.
- The lock mask gates only fill victim selection. access_update on a locked way still updates the tree.
- Stage-1 registers hold fill_set, access_set and a fill-valid flag. Stage 2 reads the tree and lock flops combinationally.

## Timing
- Fill latency 1 cycle: fill_en in cycle N produces fill_way/fill_way_valid in N+1. The tree update is written at the end of N+1.
- Back-to-back fills on the same set are legal every cycle. The fill issued in N+1 sees the update from the fill issued in N, because the read happens in its stage 2. No bypass is needed.
- access_update_en is sampled only in the cycle after access_en. access_update_en without a preceding access_en is ignored.
- A lock_en in the same cycle as a stage-2 fill on the same set is not visible to that fill. It is visible to the next one.
- Reset (reset=0, asynchronous): all tree bits 0, all locks 0, stage-1 flags 0, fill_way=0, fill_way_valid=0. Any in-flight fill or access is dropped. Normal operation resumes on the first edge after reset returns to 1.
- Outputs are registered-state-driven combinational. No combinational path from fill_en to fill_way.

## Structure
- Shared package l2_lru_pkg: tree-bit-count and index-width functions, and typedefs set_idx_t / way_idx_t / lock_mask_t.
- One sub-module, plru_tree_logic: combinational victim walk (tree bits + lock mask → way, valid) and MRU-update function (tree bits + way → new bits). The update is instantiated twice for merged updates.
- Top level owns the flop arrays, stage-1 registers and merge ordering.

## Test plan
All scenarios use NUM_SETS=4, NUM_WAYS=4.
- Reset, then fill set 0 on four consecutive cycles → fill_way 0,2,1,3, each with fill_way_valid=1, one cycle after each fill_en.
- Reset; access_en set 1, next cycle access_update way 0; then fill set 1 → fill_way=2.
- Lock ways 0 and 1 of set 2; fill set 2 four times → 2,3,2,3. Fills of set 0 are unaffected and return 0 first.
- Lock all four ways of set 3; fill → fill_way_valid=0, fill_way=0, tree unchanged. Unlock way 1; fill → way 1 valid.
- Reset; access_en and fill_en on set 0 in cycle N; in N+1 access_update way 3 with fill victim 0 (merged) → next fill returns way 2.
- Fill_en, then assert reset in the next cycle → fill_way_valid=0 immediately and locks cleared. After release, fill → way 0.
